// File: rtl/dp_pkg.sv
// Shared types for the self-sequencing datapath: opcodes, shifts,
// ALU operations, FSM states and the immediate sign-extension helper.
package dp_pkg;

    localparam int SEXT_W = 64;

    typedef enum logic [2:0] {
        OP_MOVI = 3'b000,
        OP_MOV  = 3'b001,
        OP_ADD  = 3'b010,
        OP_CMP  = 3'b011,
        OP_AND  = 3'b100,
        OP_MVN  = 3'b101,
        OP_NOP6 = 3'b110,
        OP_NOP7 = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_MVN
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_WB
    } state_e;

    // imm holds imm_w meaningful bits (imm_w < SEXT_W); callers truncate.
    function automatic logic [SEXT_W-1:0] sext_imm(
        input logic [SEXT_W-1:0] imm,
        input logic [5:0]        imm_w
    );
        logic [SEXT_W-1:0] hi;
        hi = {SEXT_W{1'b1}} << imm_w;
        return imm[imm_w - 6'd1] ? (imm | hi) : (imm & ~hi);
    endfunction

endpackage

// File: rtl/dp_regfile.sv
// General register file: one synchronous write port cleared by reset,
// one combinational operand read port and one combinational debug port.
module dp_regfile #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [RW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [RW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic [RW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata    = regs[raddr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/seq_datapath.sv
// Self-sequencing register datapath: one command per handshake, walked
// through operand load, execute and writeback by an internal FSM.
module seq_datapath
    import dp_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    parameter  int IMM_W = 8,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [RW-1:0]    cmd_rd,
    input  logic [RW-1:0]    cmd_rn,
    input  logic [RW-1:0]    cmd_rm,
    input  logic [1:0]       cmd_shift,
    input  logic [IMM_W-1:0] cmd_imm,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       status,
    input  logic [RW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef struct packed {
        op_e              op;
        logic [RW-1:0]    rd;
        logic [RW-1:0]    rn;
        logic [RW-1:0]    rm;
        shift_e           shift;
        logic [IMM_W-1:0] imm;
    } cmd_t;

    state_e           state;
    state_e           state_nxt;
    cmd_t             cq;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic [2:0]       status_q;

    logic             accept;
    logic             rf_we;
    logic [RW-1:0]    rf_raddr;
    logic [WIDTH-1:0] rf_rdata;

    logic             sel_a;
    alu_op_e          alu_op;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_out;
    logic             flag_n;
    logic             flag_v;
    logic             flag_z;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    unique case (op_e'(cmd_op))
                        OP_ADD, OP_AND, OP_CMP: state_nxt = S_LOAD_A;
                        OP_MOV, OP_MVN:         state_nxt = S_LOAD_B;
                        OP_MOVI:                state_nxt = S_EXEC;
                        default:                state_nxt = S_WB;
                    endcase
                end
            end
            S_LOAD_A: state_nxt = S_LOAD_B;
            S_LOAD_B: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_WB;
            S_WB:     state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Reset gates the handshake outputs so an aborted command never retires.
    always_comb begin
        cmd_ready = 1'b0;
        done      = 1'b0;
        rf_we     = 1'b0;
        unique case (state)
            S_IDLE: cmd_ready = !reset;
            S_WB: begin
                done  = !reset;
                rf_we = !reset && (cq.op inside
                        {OP_MOVI, OP_MOV, OP_ADD, OP_AND, OP_MVN});
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cq       <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
        end else begin
            if (accept) begin
                cq <= '{op:    op_e'(cmd_op),
                        rd:    cmd_rd,
                        rn:    cmd_rn,
                        rm:    cmd_rm,
                        shift: shift_e'(cmd_shift),
                        imm:   cmd_imm};
            end
            if (state == S_LOAD_A) begin
                a_q <= rf_rdata;
            end
            if (state == S_LOAD_B) begin
                b_q <= rf_rdata;
            end
            if (state == S_EXEC) begin
                c_q <= alu_out;
                if (cq.op == OP_CMP) begin
                    status_q <= {flag_n, flag_v, flag_z};
                end
            end
        end
    end

    assign rf_raddr = (state == S_LOAD_A) ? cq.rn : cq.rm;

    dp_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (rf_we),
        .waddr    (cq.rd),
        .wdata    (c_q),
        .raddr    (rf_raddr),
        .rdata    (rf_rdata),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_comb begin
        b_sh = b_q;
        unique case (cq.shift)
            SH_NONE: b_sh = b_q;
            SH_LSL1: b_sh = {b_q[WIDTH-2:0], 1'b0};
            SH_LSR1: b_sh = {1'b0, b_q[WIDTH-1:1]};
            SH_ASR1: b_sh = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
        endcase
    end

    assign imm_sext = WIDTH'(sext_imm(SEXT_W'(cq.imm), 6'(IMM_W)));
    assign sel_a    = cq.op inside {OP_ADD, OP_CMP, OP_AND};
    assign alu_a    = sel_a ? a_q : '0;
    assign alu_b    = (cq.op == OP_MOVI) ? imm_sext : b_sh;

    always_comb begin
        alu_op = ALU_ADD;
        unique case (1'b1)
            cq.op == OP_CMP: alu_op = ALU_SUB;
            cq.op == OP_AND: alu_op = ALU_AND;
            cq.op == OP_MVN: alu_op = ALU_MVN;
            default:         alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_out = '0;
        unique case (alu_op)
            ALU_ADD: alu_out = alu_a + alu_b;
            ALU_SUB: alu_out = alu_a - alu_b;
            ALU_AND: alu_out = alu_a & alu_b;
            ALU_MVN: alu_out = ~alu_b;
        endcase
    end

    // V is the signed-overflow rule for A-B; only CMP latches the flags.
    assign flag_n = alu_out[WIDTH-1];
    assign flag_z = (alu_out == '0);
    assign flag_v = (alu_a[WIDTH-1] ^ alu_b[WIDTH-1]) &
                    (alu_out[WIDTH-1] ^ alu_a[WIDTH-1]);

    assign result = c_q;
    assign status = status_q;

endmodule

// File: tb/tb_seq_datapath.sv
// Directed bench: a 16-bit DUT plus 32-bit and 8-bit copies driven
// from the same command bus, checked against hand-computed values.
module tb_seq_datapath;

    localparam logic [2:0] MOVI = 3'd0;
    localparam logic [2:0] MOV  = 3'd1;
    localparam logic [2:0] ADD  = 3'd2;
    localparam logic [2:0] CMP  = 3'd3;
    localparam logic [2:0] AND  = 3'd4;
    localparam logic [2:0] MVN  = 3'd5;
    localparam logic [2:0] NOP  = 3'd6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = '0;
    logic [2:0]  cmd_rd = '0;
    logic [2:0]  cmd_rn = '0;
    logic [2:0]  cmd_rm = '0;
    logic [1:0]  cmd_shift = '0;
    logic [7:0]  cmd_imm = '0;
    logic [2:0]  dbg_addr = '0;

    logic        cmd_ready, done;
    logic [15:0] result, dbg_data;
    logic [2:0]  status;
    logic        rdy32, done32;
    logic [31:0] result32, dbg32;
    logic [2:0]  status32;
    logic        rdy8, done8;
    logic [7:0]  result8, dbg8;
    logic [2:0]  status8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_datapath #(.WIDTH(16), .NREGS(8), .IMM_W(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_rd(cmd_rd),
        .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_shift(cmd_shift),
        .cmd_imm(cmd_imm), .done(done), .result(result),
        .status(status), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    seq_datapath #(.WIDTH(32), .NREGS(16), .IMM_W(8)) dut32 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid),
        .cmd_ready(rdy32), .cmd_op(cmd_op), .cmd_rd({1'b0, cmd_rd}),
        .cmd_rn({1'b0, cmd_rn}), .cmd_rm({1'b0, cmd_rm}),
        .cmd_shift(cmd_shift), .cmd_imm(cmd_imm), .done(done32),
        .result(result32), .status(status32),
        .dbg_addr({1'b0, dbg_addr}), .dbg_data(dbg32)
    );

    seq_datapath #(.WIDTH(8), .NREGS(4), .IMM_W(8)) dut8 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid),
        .cmd_ready(rdy8), .cmd_op(cmd_op), .cmd_rd(cmd_rd[1:0]),
        .cmd_rn(cmd_rn[1:0]), .cmd_rm(cmd_rm[1:0]),
        .cmd_shift(cmd_shift), .cmd_imm(cmd_imm), .done(done8),
        .result(result8), .status(status8),
        .dbg_addr(dbg_addr[1:0]), .dbg_data(dbg8)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] addr,
                           input logic [15:0] e16, input logic [31:0] e32);
        dbg_addr = addr;
        #1;
        chk({tag, "_r16"}, {16'h0, dbg_data}, {16'h0, e16});
        chk({tag, "_r32"}, dbg32, e32);
    endtask

    task automatic run(input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rn, input logic [2:0] rm,
                       input logic [1:0] sh, input logic [7:0] imm,
                       input int exp_lat, input string tag);
        int lat, lat32, lat8;
        bit rdy_bad;
        lat = 0; lat32 = 0; lat8 = 0; rdy_bad = 0;
        @(negedge clk);
        chk({tag, "_rdy_in"}, {31'h0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm;
        cmd_shift = sh; cmd_imm = imm;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = ~op; cmd_rd = ~rd; cmd_rn = ~rn; cmd_rm = ~rm;
        cmd_shift = ~sh; cmd_imm = ~imm;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (cmd_ready | rdy32 | rdy8) rdy_bad = 1'b1;
            if (done) lat = i;
            if (done32) lat32 = i;
            if (done8) lat8 = i;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_lat32"}, lat32, exp_lat);
        chk({tag, "_lat8"}, lat8, exp_lat);
        chk({tag, "_rdy_busy"}, {31'h0, rdy_bad}, 32'd0);
        @(negedge clk);
        chk({tag, "_after"}, {30'h0, done, cmd_ready}, 32'd1);
    endtask

    initial begin
        logic [4:0] dpat, rpat;
        bit         seen;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {29'h0, cmd_ready, rdy32, rdy8}, 32'h7);
        chk("rst_done", {29'h0, done, done32, done8}, 32'h0);
        chk("rst_result", {16'h0, result}, 32'h0);
        chk("rst_status", {29'h0, status}, 32'h0);
        chk_reg("rst_r0", 3'd0, 16'h0, 32'h0);

        run(MOVI, 3'd0, 3'd0, 3'd0, 2'd0, 8'hFD, 2, "movi_r0");
        chk_reg("r0", 3'd0, 16'hFFFD, 32'hFFFF_FFFD);
        chk("r0_w8", {24'h0, dbg8}, 32'hFD);
        chk("movi_result", {16'h0, result}, 32'hFFFD);
        chk("movi_status", {29'h0, status}, 32'h0);

        run(MOVI, 3'd1, 3'd0, 3'd0, 2'd0, 8'h07, 2, "movi_r1");
        run(ADD, 3'd2, 3'd1, 3'd1, 2'd1, 8'h00, 4, "add_lsl");
        chk_reg("r2", 3'd2, 16'h0015, 32'h15);
        chk("r2_w8", {24'h0, dbg8}, 32'h15);
        chk("add_res32", result32, 32'h15);
        chk("add_res8", {24'h0, result8}, 32'h15);
        chk("add_status", {29'h0, status}, 32'h0);

        run(MOVI, 3'd3, 3'd0, 3'd0, 2'd0, 8'h7F, 2, "movi_r3");
        run(MOV, 3'd4, 3'd0, 3'd3, 2'd1, 8'h00, 3, "mov_r4");
        for (int k = 0; k < 7; k++)
            run(MOV, 3'd4, 3'd0, 3'd4, 2'd1, 8'h00, 3, "mov_r4_rep");
        chk_reg("r4", 3'd4, 16'h7F00, 32'h7F00);

        run(MOV, 3'd7, 3'd0, 3'd4, 2'd1, 8'h00, 3, "mov_r7");
        chk_reg("r7", 3'd7, 16'hFE00, 32'hFE00);

        run(CMP, 3'd6, 3'd4, 3'd7, 2'd0, 8'h00, 4, "cmp_ovf");
        chk("cmp_ovf_st", {29'h0, status}, 32'h6);
        chk("cmp_ovf_st32", {29'h0, status32}, 32'h4);
        chk("cmp_ovf_res", {16'h0, result}, 32'h8100);
        chk("cmp_ovf_res32", result32, 32'hFFFF_8100);
        chk_reg("cmp_nowr", 3'd6, 16'h0, 32'h0);

        run(CMP, 3'd6, 3'd4, 3'd0, 2'd0, 8'h00, 4, "cmp_r4r0");
        chk("cmp_r4r0_st", {29'h0, status}, 32'h0);
        chk("cmp_r4r0_res", {16'h0, result}, 32'h7F03);
        chk_reg("cmp_r4r0_nowr", 3'd6, 16'h0, 32'h0);

        run(CMP, 3'd0, 3'd1, 3'd1, 2'd0, 8'h00, 4, "cmp_eq");
        chk("cmp_eq_st", {29'h0, status}, 32'h1);
        chk("cmp_eq_st32", {29'h0, status32}, 32'h1);
        chk("cmp_eq_st8", {29'h0, status8}, 32'h1);
        chk_reg("cmp_eq_r0", 3'd0, 16'hFFFD, 32'hFFFF_FFFD);

        run(AND, 3'd3, 3'd2, 3'd1, 2'd0, 8'h00, 4, "and");
        chk_reg("r3_and", 3'd3, 16'h0005, 32'h5);

        run(MOV, 3'd6, 3'd0, 3'd0, 2'd2, 8'h00, 3, "mov_lsr");
        chk_reg("r6_lsr", 3'd6, 16'h7FFE, 32'h7FFF_FFFE);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = MVN; cmd_rd = 3'd5; cmd_rn = 3'd0; cmd_rm = 3'd1;
        cmd_shift = 2'd3; cmd_imm = 8'h00;
        @(posedge clk);
        #1;
        cmd_op = NOP; cmd_rd = 3'd2; cmd_rm = 3'd2; cmd_shift = 2'd0;
        dpat = '0; rpat = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dpat[i] = done;
            rpat[i] = cmd_ready;
        end
        cmd_valid = 1'b0;
        chk("b2b_done", {27'h0, dpat}, 32'b10100);
        chk("b2b_ready", {27'h0, rpat}, 32'b01000);
        @(negedge clk);
        chk("b2b_idle", {31'h0, cmd_ready}, 32'd1);
        chk_reg("r5_mvn", 3'd5, 16'hFFFC, 32'hFFFF_FFFC);
        chk_reg("r2_nop", 3'd2, 16'h0015, 32'h15);
        chk("nop_status", {29'h0, status}, 32'h1);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = ADD; cmd_rd = 3'd6; cmd_rn = 3'd1; cmd_rm = 3'd1;
        cmd_shift = 2'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done | done32 | done8) seen = 1'b1;
            if (i == 0)
                chk("abort_ready", {29'h0, cmd_ready, rdy32, rdy8}, 32'h7);
        end
        chk("abort_nodone", {31'h0, seen}, 32'd0);
        chk_reg("abort_r6", 3'd6, 16'h0, 32'h0);
        chk("abort_result", {16'h0, result}, 32'h0);
        chk("abort_status", {29'h0, status}, 32'h0);

        run(MOVI, 3'd2, 3'd0, 3'd0, 2'd0, 8'h80, 2, "movi_neg");
        chk_reg("r2_neg", 3'd2, 16'hFF80, 32'hFFFF_FF80);
        chk("r2_neg_w8", {24'h0, dbg8}, 32'h80);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
